// File: rtl/map_pkg.sv
// map_pkg: shared types and field layout for the map collision scanner.
//   - bit positions of the ground / fence / spike table words
//   - default table sizes
//   - scan FSM state encoding and the 11-bit coordinate type that holds
//     every sum and difference without wrapping
package map_pkg;

  localparam int GROUND_N_DEF = 16;
  localparam int FENCE_N_DEF  = 16;
  localparam int SPIKE_N_DEF  = 6;

  localparam int GND_W = 29;
  localparam int FEN_W = 29;
  localparam int SPK_W = 21;

  // ground word: {length, y_loc, x_start}
  localparam int GND_X_LSB   = 0;
  localparam int GND_X_MSB   = 9;
  localparam int GND_Y_LSB   = 10;
  localparam int GND_Y_MSB   = 18;
  localparam int GND_LEN_LSB = 19;
  localparam int GND_LEN_MSB = 28;

  // fence word: {length, x_loc, y_start}
  localparam int FEN_Y_LSB   = 0;
  localparam int FEN_Y_MSB   = 8;
  localparam int FEN_X_LSB   = 9;
  localparam int FEN_X_MSB   = 18;
  localparam int FEN_LEN_LSB = 19;
  localparam int FEN_LEN_MSB = 28;

  // spike word: {dir, y, x}
  localparam int SPK_X_LSB   = 0;
  localparam int SPK_X_MSB   = 9;
  localparam int SPK_Y_LSB   = 10;
  localparam int SPK_Y_MSB   = 18;
  localparam int SPK_DIR_LSB = 19;
  localparam int SPK_DIR_MSB = 20;

  localparam int COORD_W = 11;
  typedef logic [COORD_W-1:0] coord_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    GROUND = 3'd1,
    FENCE  = 3'd2,
    HAZARD = 3'd3,
    DONE   = 3'd4
  } scan_state_t;

endpackage

// File: rtl/map_collision_scanner_if.sv
// map_collision_scanner_if: scan request / contact-result bundle between the
// ball-physics logic (master) and the map collision scanner (slave).
//   start            one-cycle scan request
//   BallX/BallY      ball centre, BallSize ball half-size
//   busy, done       scan in progress / one-cycle result-update pulse
//   on_ground, ground_y, hit_left_wall, hit_right_wall, hit_spike, at_exit
//                    contact flags, stable between done pulses
interface map_collision_scanner_if;
  logic       start;
  logic [9:0] BallX;
  logic [9:0] BallY;
  logic [9:0] BallSize;
  logic       busy;
  logic       done;
  logic       on_ground;
  logic [8:0] ground_y;
  logic       hit_left_wall;
  logic       hit_right_wall;
  logic       hit_spike;
  logic       at_exit;

  modport master (
    output start, BallX, BallY, BallSize,
    input  busy, done, on_ground, ground_y,
    input  hit_left_wall, hit_right_wall, hit_spike, at_exit
  );

  modport slave (
    input  start, BallX, BallY, BallSize,
    output busy, done, on_ground, ground_y,
    output hit_left_wall, hit_right_wall, hit_spike, at_exit
  );
endinterface

// File: rtl/map_range_cmp.sv
// map_range_cmp: combinational per-axis comparator.
//   near   = |a - b| <= r   (difference taken larger-minus-smaller, no wrap)
//   in_win = lo <= v <= hi
// All operands are 11-bit so callers can pass sums of 10-bit values intact.
module map_range_cmp
  import map_pkg::*;
(
  input  coord_t a,
  input  coord_t b,
  input  coord_t r,
  input  coord_t v,
  input  coord_t lo,
  input  coord_t hi,
  output logic   near,
  output logic   in_win
);

  coord_t diff;

  always_comb begin
    diff   = (a >= b) ? (a - b) : (b - a);
    near   = (diff <= r);
    in_win = (v >= lo) && (v <= hi);
  end

endmodule

// File: rtl/map_collision_scanner.sv
// map_collision_scanner: per-frame walk of the level tables against the ball.
// On start (IDLE only) the ball is latched, then one table entry is checked
// per clock: GROUND_N ground entries, FENCE_N fences, SPIKE_N spikes and the
// exit. Hits collect in accumulators; the full result set is published in one
// step so the physics side never sees a half-updated frame.
// Ports:
//   Clk, Reset_n   clock, async active-low reset
//   scan           request/result bundle (slave side)
//   info_ground    {length, y_loc, x_start} per platform
//   info_fence     {length, x_loc, y_start} per fence
//   info_spince    {dir, y, x} per spike (dir unused)
//   info_exit      [0]=x, [1]=y
module map_collision_scanner
  import map_pkg::*;
#(
  parameter int GROUND_N = GROUND_N_DEF,
  parameter int FENCE_N  = FENCE_N_DEF,
  parameter int SPIKE_N  = SPIKE_N_DEF,
  parameter int LAND_TOL = 4,
  parameter int SPIKE_R  = 8,
  parameter int EXIT_R   = 16
) (
  input  logic                          Clk,
  input  logic                          Reset_n,
  map_collision_scanner_if.slave        scan,
  input  logic [GROUND_N-1:0][GND_W-1:0] info_ground,
  input  logic [FENCE_N-1:0][FEN_W-1:0]  info_fence,
  input  logic [SPIKE_N-1:0][SPK_W-1:0]  info_spince,
  input  logic [1:0][9:0]                info_exit
);

  localparam int MAX_GF = (GROUND_N > FENCE_N) ? GROUND_N : FENCE_N;
  localparam int MAXN   = (MAX_GF > SPIKE_N + 1) ? MAX_GF : SPIKE_N + 1;
  localparam int IDX_W  = ($clog2(MAXN) < 1) ? 1 : $clog2(MAXN);
  typedef logic [IDX_W-1:0] idx_t;

  scan_state_t state_q, state_d;
  idx_t        idx_q, idx_d;
  coord_t      bx_q, bx_d, by_q, by_d, bs_q, bs_d;

  // accumulators for the scan in flight
  logic        found_q, found_d;
  logic [8:0]  best_y_q, best_y_d;
  logic        left_q, left_d, right_q, right_d;
  logic        spike_q, spike_d, exit_q, exit_d;

  // published results
  logic        og_q, og_d;
  logic [8:0]  gy_q, gy_d;
  logic        lw_q, lw_d, rw_q, rw_d, sp_q, sp_d, ex_q, ex_d;

  // live table entry at the current index
  logic [GND_W-1:0] g_ent;
  logic [FEN_W-1:0] f_ent;
  logic [SPK_W-1:0] s_ent;
  logic             is_exit;

  always_comb begin
    g_ent = '0;
    f_ent = '0;
    s_ent = '0;
    for (int i = 0; i < GROUND_N; i++)
      if (idx_q == idx_t'(i)) g_ent = info_ground[i];
    for (int i = 0; i < FENCE_N; i++)
      if (idx_q == idx_t'(i)) f_ent = info_fence[i];
    for (int i = 0; i < SPIKE_N; i++)
      if (idx_q == idx_t'(i)) s_ent = info_spince[i];
  end

  assign is_exit = (idx_q == idx_t'(SPIKE_N));

  logic [9:0] g_x, g_len, f_x, f_len, s_x;
  logic [8:0] g_y, f_y, s_y;
  logic       unused_dir;

  assign g_x   = g_ent[GND_X_MSB:GND_X_LSB];
  assign g_y   = g_ent[GND_Y_MSB:GND_Y_LSB];
  assign g_len = g_ent[GND_LEN_MSB:GND_LEN_LSB];
  assign f_y   = f_ent[FEN_Y_MSB:FEN_Y_LSB];
  assign f_x   = f_ent[FEN_X_MSB:FEN_X_LSB];
  assign f_len = f_ent[FEN_LEN_MSB:FEN_LEN_LSB];
  assign s_x   = s_ent[SPK_X_MSB:SPK_X_LSB];
  assign s_y   = s_ent[SPK_Y_MSB:SPK_Y_LSB];
  assign unused_dir = ^s_ent[SPK_DIR_MSB:SPK_DIR_LSB];

  // One comparator per axis, operands steered by the table being walked.
  coord_t x_a, x_b, x_r, x_v, x_lo, x_hi;
  coord_t y_a, y_b, y_r, y_v, y_lo, y_hi;
  logic   x_near, x_in, y_near, y_in;

  always_comb begin
    x_a = bx_q; x_b = '0; x_r = '0; x_v = '0; x_lo = '0; x_hi = '0;
    y_a = by_q; y_b = '0; y_r = '0; y_v = '0; y_lo = '0; y_hi = '0;
    case (state_q)
      GROUND: begin
        x_v  = bx_q;
        x_lo = coord_t'(g_x);
        x_hi = coord_t'(g_x) + coord_t'(g_len);
        y_v  = by_q + bs_q;
        y_lo = coord_t'(g_y);
        y_hi = coord_t'(g_y) + coord_t'(LAND_TOL);
      end
      FENCE: begin
        y_v  = by_q;
        y_lo = coord_t'(f_y);
        y_hi = coord_t'(f_y) + coord_t'(f_len);
        // side contact: fence within BallSize of the centre, side chosen
        // below; avoids forming BallX-BallSize when it would go negative
        x_b  = coord_t'(f_x);
        x_r  = bs_q;
      end
      HAZARD: begin
        if (is_exit) begin
          x_b = coord_t'(info_exit[0]);
          y_b = coord_t'(info_exit[1]);
          x_r = coord_t'(EXIT_R);
          y_r = coord_t'(EXIT_R);
        end else begin
          x_b = coord_t'(s_x);
          y_b = coord_t'(s_y);
          x_r = bs_q + coord_t'(SPIKE_R);
          y_r = bs_q + coord_t'(SPIKE_R);
        end
      end
      default: ;
    endcase
  end

  map_range_cmp u_cmp_x (
    .a(x_a), .b(x_b), .r(x_r), .v(x_v), .lo(x_lo), .hi(x_hi),
    .near(x_near), .in_win(x_in)
  );

  map_range_cmp u_cmp_y (
    .a(y_a), .b(y_b), .r(y_r), .v(y_v), .lo(y_lo), .hi(y_hi),
    .near(y_near), .in_win(y_in)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    bx_d     = bx_q;
    by_d     = by_q;
    bs_d     = bs_q;
    found_d  = found_q;
    best_y_d = best_y_q;
    left_d   = left_q;
    right_d  = right_q;
    spike_d  = spike_q;
    exit_d   = exit_q;
    og_d     = og_q;
    gy_d     = gy_q;
    lw_d     = lw_q;
    rw_d     = rw_q;
    sp_d     = sp_q;
    ex_d     = ex_q;

    case (state_q)
      IDLE: begin
        if (scan.start) begin
          state_d  = GROUND;
          idx_d    = '0;
          bx_d     = coord_t'(scan.BallX);
          by_d     = coord_t'(scan.BallY);
          bs_d     = coord_t'(scan.BallSize);
          found_d  = 1'b0;
          best_y_d = '0;
          left_d   = 1'b0;
          right_d  = 1'b0;
          spike_d  = 1'b0;
          exit_d   = 1'b0;
        end
      end

      GROUND: begin
        // strict < keeps the earliest platform among equal heights
        if ((g_len != '0) && x_in && y_in && (!found_q || (g_y < best_y_q))) begin
          found_d  = 1'b1;
          best_y_d = g_y;
        end
        if (idx_q == idx_t'(GROUND_N - 1)) begin
          state_d = FENCE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + idx_t'(1);
        end
      end

      FENCE: begin
        if ((f_len != '0) && y_in && x_near) begin
          if (coord_t'(f_x) <= bx_q) left_d  = 1'b1;
          else                       right_d = 1'b1;
        end
        if (idx_q == idx_t'(FENCE_N - 1)) begin
          state_d = HAZARD;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + idx_t'(1);
        end
      end

      HAZARD: begin
        if (x_near && y_near) begin
          if (is_exit) exit_d  = 1'b1;
          else         spike_d = 1'b1;
        end
        if (is_exit) begin
          // publish including this cycle's exit result so outputs and done
          // appear together in the DONE cycle
          state_d = DONE;
          idx_d   = '0;
          og_d    = found_d;
          gy_d    = best_y_d;
          lw_d    = left_d;
          rw_d    = right_d;
          sp_d    = spike_d;
          ex_d    = exit_d;
        end else begin
          idx_d = idx_q + idx_t'(1);
        end
      end

      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      bx_q     <= '0;
      by_q     <= '0;
      bs_q     <= '0;
      found_q  <= 1'b0;
      best_y_q <= '0;
      left_q   <= 1'b0;
      right_q  <= 1'b0;
      spike_q  <= 1'b0;
      exit_q   <= 1'b0;
      og_q     <= 1'b0;
      gy_q     <= '0;
      lw_q     <= 1'b0;
      rw_q     <= 1'b0;
      sp_q     <= 1'b0;
      ex_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      bx_q     <= bx_d;
      by_q     <= by_d;
      bs_q     <= bs_d;
      found_q  <= found_d;
      best_y_q <= best_y_d;
      left_q   <= left_d;
      right_q  <= right_d;
      spike_q  <= spike_d;
      exit_q   <= exit_d;
      og_q     <= og_d;
      gy_q     <= gy_d;
      lw_q     <= lw_d;
      rw_q     <= rw_d;
      sp_q     <= sp_d;
      ex_q     <= ex_d;
    end
  end

  assign scan.busy           = (state_q == GROUND) || (state_q == FENCE) || (state_q == HAZARD);
  assign scan.done           = (state_q == DONE);
  assign scan.on_ground      = og_q;
  assign scan.ground_y       = gy_q;
  assign scan.hit_left_wall  = lw_q;
  assign scan.hit_right_wall = rw_q;
  assign scan.hit_spike      = sp_q;
  assign scan.at_exit        = ex_q;

endmodule

// File: tb/tb_map_collision_scanner.sv
// Bench for map_collision_scanner: directed vector table, multi-cycle corner
// sequences (ignored starts, mid-scan ball change, mid-scan reset) and random
// frames checked against a plain-integer model of the contact rules.
module tb_map_collision_scanner;

  localparam int GN = 16, FN = 16, SN = 6, LT = 4, SR = 8, ER = 16;
  localparam int LAT = GN + FN + SN + 2;

  logic Clk = 1'b0;
  logic Reset_n = 1'b0;
  logic [GN-1:0][28:0] gnd;
  logic [FN-1:0][28:0] fen;
  logic [SN-1:0][20:0] spk;
  logic [1:0][9:0]     ext;

  map_collision_scanner_if sif ();

  map_collision_scanner #(
    .GROUND_N(GN), .FENCE_N(FN), .SPIKE_N(SN),
    .LAND_TOL(LT), .SPIKE_R(SR), .EXIT_R(ER)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n), .scan(sif),
    .info_ground(gnd), .info_fence(fen), .info_spince(spk), .info_exit(ext)
  );

  always #5 Clk = ~Clk;

  typedef struct { int og; int gy; int lw; int rw; int sp; int ex; } res_t;
  typedef struct { int setup; int bx; int by; int bs; res_t exp; } vec_t;

  int   total = 0;
  int   passed = 0;
  vec_t vecs[$];

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  function automatic logic [28:0] gw(input int x, input int y, input int len);
    return {10'(len), 9'(y), 10'(x)};
  endfunction

  function automatic logic [28:0] fw(input int x, input int y, input int len);
    return {10'(len), 10'(x), 9'(y)};
  endfunction

  function automatic logic [20:0] sw(input int x, input int y);
    return {2'd3, 9'(y), 10'(x)};
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic res_t mk(input int og, input int gy, input int lw,
                              input int rw, input int sp, input int ex);
    res_t r;
    r.og = og; r.gy = gy; r.lw = lw; r.rw = rw; r.sp = sp; r.ex = ex;
    return r;
  endfunction

  // Contact rules evaluated directly on integers over the current tables.
  function automatic res_t model(input int bx, input int by, input int bs);
    res_t r;
    int best, xs, yl, ln, sx, sy;
    logic [28:0] w;
    logic [20:0] s;
    r = mk(0, 0, 0, 0, 0, 0);
    best = -1;
    for (int i = 0; i < GN; i++) begin
      w = gnd[i];
      xs = int'(w[9:0]); yl = int'(w[18:10]); ln = int'(w[28:19]);
      if (ln != 0 && bx >= xs && bx <= xs + ln && by + bs >= yl &&
          by + bs <= yl + LT && (best < 0 || yl < best))
        best = yl;
    end
    if (best >= 0) begin r.og = 1; r.gy = best; end
    for (int i = 0; i < FN; i++) begin
      w = fen[i];
      yl = int'(w[8:0]); xs = int'(w[18:9]); ln = int'(w[28:19]);
      if (ln != 0 && by >= yl && by <= yl + ln) begin
        if (xs <= bx && bx - bs <= xs) r.lw = 1;
        if (xs > bx && bx + bs >= xs) r.rw = 1;
      end
    end
    for (int i = 0; i < SN; i++) begin
      s = spk[i];
      sx = int'(s[9:0]); sy = int'(s[18:10]);
      if (iabs(bx - sx) <= bs + SR && iabs(by - sy) <= bs + SR) r.sp = 1;
    end
    if (iabs(bx - int'(ext[0])) <= ER && iabs(by - int'(ext[1])) <= ER) r.ex = 1;
    return r;
  endfunction

  task automatic setup(input int id);
    gnd = '0; fen = '0; spk = '0; ext = '0;
    case (id)
      0: gnd[0] = gw(0, 430, 639);
      1: begin gnd[0] = gw(0, 430, 639); gnd[1] = gw(300, 430, 50); gnd[2] = gw(300, 431, 50); end
      2: fen[2] = fw(0, 0, 479);
      3: fen[3] = fw(639, 0, 479);
      4: spk[0] = sw(60, 420);
      5: begin ext[0] = 10'd20; ext[1] = 10'd20; end
      6: gnd[4] = gw(100, 200, 0);
      7: gnd[5] = gw(100, 200, 10);
      8: begin gnd[3] = gw(0, 300, 600); gnd[9] = gw(0, 298, 600); end
      9: begin fen[0] = fw(100, 0, 100); fen[1] = fw(110, 0, 100); end
      10: spk[5] = sw(200, 200);
      11: begin ext[0] = 10'd500; ext[1] = 10'd300; end
      12: begin gnd[0] = gw(0, 430, 639); gnd[15] = gw(0, 427, 639); end
      13: fen[15] = fw(0, 0, 0);
      default: ;
    endcase
  endtask

  task automatic add_vec(input int su, input int bx, input int by, input int bs, input res_t e);
    vec_t v;
    v.setup = su; v.bx = bx; v.by = by; v.bs = bs; v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic get_dut(output res_t r);
    r = mk(int'(sif.on_ground), int'(sif.ground_y), int'(sif.hit_left_wall),
           int'(sif.hit_right_wall), int'(sif.hit_spike), int'(sif.at_exit));
  endtask

  task automatic check_res(input string tag, input res_t a, input res_t e);
    chk({tag, ".on_ground"}, a.og, e.og);
    chk({tag, ".ground_y"},  a.gy, e.gy);
    chk({tag, ".left"},      a.lw, e.lw);
    chk({tag, ".right"},     a.rw, e.rw);
    chk({tag, ".spike"},     a.sp, e.sp);
    chk({tag, ".exit"},      a.ex, e.ex);
  endtask

  // ev_kind: 0 none, 1 extra start, 2 BallX change, 3 reset pulse (all in
  // cycle T+ev_cyc), 4 start held during the DONE cycle.
  // Returns with the bench sitting in the DONE cycle (lat = cycle offset),
  // or lat = -1 if no done came within the budget.
  task automatic scan(input int ev_kind, input int ev_cyc, input int ev_val,
                      output int lat, output int busy_bad);
    bit rst_seen;
    rst_seen = 1'b0;
    lat = -1;
    busy_bad = 0;
    sif.start = 1'b1;
    tick();
    sif.start = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      if (sif.done) begin
        lat = c;
        if (sif.busy !== 1'b0) busy_bad++;
        if (ev_kind == 4) sif.start = 1'b1;
        break;
      end
      if (!rst_seen && sif.busy !== 1'b1) busy_bad++;
      if (c == ev_cyc) begin
        case (ev_kind)
          1: sif.start = 1'b1;
          2: sif.BallX = 10'(ev_val);
          3: begin Reset_n = 1'b0; rst_seen = 1'b1; end
          default: ;
        endcase
      end
      tick();
      sif.start = 1'b0;
      Reset_n = 1'b1;
    end
  endtask

  task automatic run_one(input string tag, input int bx, input int by, input int bs,
                         input res_t e, input int ev_kind, input int ev_cyc, input int ev_val);
    int lat, bb;
    res_t a;
    sif.BallX = 10'(bx); sif.BallY = 10'(by); sif.BallSize = 10'(bs);
    scan(ev_kind, ev_cyc, ev_val, lat, bb);
    chk({tag, ".latency"}, lat, LAT);
    chk({tag, ".busy_window"}, bb, 0);
    get_dut(a);
    check_res(tag, a, e);
    tick();
    sif.start = 1'b0;
    chk({tag, ".done_width"}, int'(sif.done), 0);
    chk({tag, ".idle_after"}, int'(sif.busy), 0);
  endtask

  initial begin
    int   lat, bb, ndone, busy_seen, ev, cyc, val, bx, by, bs;
    res_t a, e;

    sif.start = 1'b0; sif.BallX = '0; sif.BallY = '0; sif.BallSize = '0;
    setup(-1);
    Reset_n = 1'b0;
    repeat (3) tick();
    get_dut(a);
    check_res("reset", a, mk(0, 0, 0, 0, 0, 0));
    chk("reset.busy", int'(sif.busy), 0);
    chk("reset.done", int'(sif.done), 0);
    Reset_n = 1'b1;
    tick();

    add_vec(0, 320, 420, 10, mk(1, 430, 0, 0, 0, 0));
    add_vec(1, 320, 420, 10, mk(1, 430, 0, 0, 0, 0));
    add_vec(2,   8, 200, 10, mk(0, 0, 1, 0, 0, 0));
    add_vec(3, 631, 200, 10, mk(0, 0, 0, 1, 0, 0));
    add_vec(4,  60, 410,  5, mk(0, 0, 0, 0, 1, 0));
    add_vec(5,  20,  20, 10, mk(0, 0, 0, 0, 0, 1));
    add_vec(6, 105, 190, 10, mk(0, 0, 0, 0, 0, 0));
    add_vec(7, 110, 194, 10, mk(1, 200, 0, 0, 0, 0));
    add_vec(7, 110, 195, 10, mk(0, 0, 0, 0, 0, 0));
    add_vec(7, 111, 194, 10, mk(0, 0, 0, 0, 0, 0));
    add_vec(7, 100, 190, 10, mk(1, 200, 0, 0, 0, 0));
    add_vec(8,  50, 290, 10, mk(1, 298, 0, 0, 0, 0));
    add_vec(9, 105,  50,  5, mk(0, 0, 1, 1, 0, 0));
    add_vec(10, 213, 187, 5, mk(0, 0, 0, 0, 1, 0));
    add_vec(10, 214, 200, 5, mk(0, 0, 0, 0, 0, 0));
    add_vec(11, 516, 284, 3, mk(0, 0, 0, 0, 0, 1));
    add_vec(11, 517, 300, 3, mk(0, 0, 0, 0, 0, 0));
    add_vec(12, 320, 420, 10, mk(1, 427, 0, 0, 0, 0));
    add_vec(13,   8, 200, 10, mk(0, 0, 0, 0, 0, 0));

    foreach (vecs[i]) begin
      setup(vecs[i].setup);
      run_one($sformatf("vec%0d", i), vecs[i].bx, vecs[i].by, vecs[i].bs,
              vecs[i].exp, 0, 0, 0);
    end

    // extra start at T+5 is dropped: one done at T+40, nothing queued after
    setup(0);
    run_one("start_mid", 320, 420, 10, mk(1, 430, 0, 0, 0, 0), 1, 5, 0);
    ndone = 0; busy_seen = 0;
    for (int c = 0; c < 45; c++) begin
      if (sif.done) ndone++;
      if (sif.busy) busy_seen++;
      tick();
    end
    chk("start_mid.no_second_done", ndone, 0);
    chk("start_mid.no_second_busy", busy_seen, 0);

    // BallX moved at T+10 off every platform; latched value still lands
    run_one("ball_change", 320, 420, 10, mk(1, 430, 0, 0, 0, 0), 2, 10, 900);

    // start held in the DONE cycle must not begin a new scan
    run_one("start_in_done", 320, 420, 10, mk(1, 430, 0, 0, 0, 0), 4, 0, 0);

    // reset at T+20: no done, published outputs cleared
    sif.BallX = 10'd320; sif.BallY = 10'd420; sif.BallSize = 10'd10;
    scan(3, 20, 0, lat, bb);
    chk("reset_mid.no_done", lat, -1);
    chk("reset_mid.busy_window", bb, 0);
    get_dut(a);
    check_res("reset_mid", a, mk(0, 0, 0, 0, 0, 0));
    chk("reset_mid.busy", int'(sif.busy), 0);
    setup(2);
    run_one("after_reset", 8, 200, 10, mk(0, 0, 1, 0, 0, 0), 0, 0, 0);

    // random frames against the model, sometimes with a mid-scan ball change
    for (int it = 0; it < 30; it++) begin
      setup(-1);
      for (int i = 0; i < GN; i++)
        gnd[i] = gw($urandom_range(0, 159), $urandom_range(0, 170),
                    ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 60));
      for (int i = 0; i < FN; i++)
        fen[i] = fw($urandom_range(0, 159), $urandom_range(0, 159),
                    ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 60));
      for (int i = 0; i < SN; i++)
        spk[i] = sw($urandom_range(0, 159), $urandom_range(0, 159));
      ext[0] = 10'($urandom_range(0, 159));
      ext[1] = 10'($urandom_range(0, 159));
      bx = $urandom_range(0, 159);
      by = $urandom_range(0, 159);
      bs = $urandom_range(0, 15);
      e  = model(bx, by, bs);
      ev  = ($urandom_range(0, 1) == 1) ? 2 : 0;
      cyc = $urandom_range(1, 39);
      val = $urandom_range(0, 1023);
      run_one($sformatf("rand%0d", it), bx, by, bs, e, ev, cyc, val);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
